cursor_pos_ctrl: RTL and testbench
==================================

// Module: cursor_pos_ctrl
// PURPOSE
//  Accumulates signed relative mouse deltas into an absolute, screen-clamped cursor position.
//  Sequences Avalon-MM writes of X, then Y, into the 12-bit cursor PIO output registers.
//  The PIO outputs drive the ball/cursor renderer. The NIOS reads the registers back, so the
//  hardware keeps the PIO registers current without software polling the mouse.
// PARAMETERS
//  XW      12   position width; matches the 12-bit PIO data registers
//  DW      9    delta width, two's complement
//  X_MAX   639  max X (inclusive); min is 0
//  Y_MAX   479  max Y (inclusive); min is 0
//  X_INIT  320  X after reset or recenter
//  Y_INIT  240  Y after reset or recenter
//  AW      4    master address width
//  ADDR_X  0    address of the X PIO data register
//  ADDR_Y  1    address of the Y PIO data register
//  ADDR_B  2    address of the button PIO data register (CURSOR_BTN_EN only)
// PORTS
//  clk              in   1   system clock
//  reset            in   1   asynchronous, active-high reset
//  delta_valid      in   1   delta packet valid
//  delta_ready      out  1   registered; high only in IDLE
//  delta_dx         in   DW  signed X delta
//  delta_dy         in   DW  signed Y delta
//  delta_btn        in   3   button bits {mid,right,left}
//  recenter         in   1   1-cycle pulse: return to INIT and rewrite the PIOs
//  avm_address      out  AW  target register address
//  avm_chipselect   out  1   write strobe, active high
//  avm_write_n      out  1   active-low write
//  avm_writedata    out  32  zero-extended position or buttons
//  avm_waitrequest  in   1   stall; hold all avm_* outputs stable while high
//  busy             out  1   high while the FSM is not in IDLE
//  cur_x            out  XW  current accumulated X
//  cur_y            out  XW  current accumulated Y
// BEHAVIOUR
//  Reset values: cur_x=X_INIT, cur_y=Y_INIT, FSM=IDLE, delta_ready=0, avm_chipselect=0,
//   avm_write_n=1, avm_address=0, avm_writedata=0, busy=0.
//   delta_ready goes to 1 on the first clock edge after reset deasserts.
//   A reset asserted mid-write aborts the write immediately; no partial-write recovery is done.
//  FSM states: IDLE -> WR_X -> WR_Y -> [WR_B] -> IDLE.
//  Handshake: a delta is accepted on the cycle where delta_valid & delta_ready are both high.
//  On accept, cur_x/cur_y update on that same edge:
//   - arithmetic is signed in XW+2 bits: sum = {2'b0,cur} + sext(delta);
//   - sum < 0 clamps to 0; sum > MAX clamps to MAX; otherwise sum is used;
//   - a Y delta is added directly (screen-down positive); the block does no inversion.
//  After accept, delta_ready drops and the FSM enters WR_X on the next cycle.
//  WR_X: avm_chipselect=1, avm_write_n=0, avm_address=ADDR_X, avm_writedata={(32-XW)'b0,cur_x}.
//   The state is held while avm_waitrequest=1. It advances on the first cycle with
//   avm_waitrequest=0, giving exactly one completed write.
//  WR_Y: the same sequence with ADDR_Y and cur_y.
//  WR_B (macro only): ADDR_B and {29'b0,btn_q}.
//  Returning to IDLE deasserts chipselect (write_n=1) and re-raises delta_ready on the same edge.
//  Latency with no stalls: accept at cycle N, X write at N+1, Y write at N+2, ready at N+3.
//   Throughput is one delta per 3 cycles (4 with the macro).
//  Every accepted delta writes X and Y, even when the clamped values are unchanged.
//  recenter:
//   - in IDLE: load INIT and run the write sequence as if a delta were accepted;
//   - same cycle as an accepted delta: recenter wins and the delta is consumed and discarded;
//   - while busy: latched as pending, applied on the return to IDLE; the delta path is held off
//     that cycle and the pending flag clears when applied.
//  A new recenter while one is already pending is merged into it.
// CONFIGURATION
//  CURSOR_BTN_EN defined: delta_btn is registered on accept and the FSM adds WR_B after WR_Y.
//  CURSOR_BTN_EN undefined:
//   - delta_btn is ignored;
//   - there is no WR_B state and the FSM goes WR_Y -> IDLE;
//   - ADDR_B is unused.
// STRUCTURE
//  Package cursor_pkg: FSM state enum {IDLE,WR_X,WR_Y,WR_B}, default X_MAX/Y_MAX/INIT constants,
//   and the clamp function (signed sum, max) -> XW bits.
//  One sub-module, cursor_axis_acc, instanced twice (X and Y). Each instance holds the register,
//   the signed add, the clamp and the INIT load.
//  The top level holds the FSM, the Avalon master drive and the recenter pending flag.
// TESTING
//  1. Reset then deassert -> cur=(320,240); writes ADDR_X data 320, then ADDR_Y data 240, are
//     absent until the first delta; delta_ready=1 one cycle after reset deassert.
//  2. dx=+5, dy=-3 with no waitrequest -> write X=325 at N+1, write Y=237 at N+2,
//     delta_ready at N+3.
//  3. cur_x=630 with dx=+100 -> X=639. cur_y=2 with dy=-256 -> Y=0.
//     Max positive delta dx=+255 from X=0 -> X=255.
//  4. Hold waitrequest=1 for 4 cycles in WR_X -> avm_* stable, busy=1, delta_ready=0;
//     exactly one X write completes; delta_valid held high meanwhile is not accepted.
//  5. recenter in the same cycle as delta dx=+50 -> X=320, Y=240 written and the delta dropped.
//     recenter during WR_Y -> a second write sequence of (320,240) follows immediately.
//  6. With CURSOR_BTN_EN defined, delta_btn=3'b101 -> third write: ADDR_B data 5, ready at N+4.
//     With CURSOR_BTN_EN undefined -> no ADDR_B write ever appears.

Source files
------------

// File: rtl/cursor_pkg.sv
// Shared types and constants for the cursor position controller.
// Holds the write-sequencer state encoding, default screen geometry and the
// saturating clamp used by both axis accumulators.
package cursor_pkg;

  localparam int POS_W    = 12;
  localparam int X_MAX_D  = 639;
  localparam int Y_MAX_D  = 479;
  localparam int X_INIT_D = 320;
  localparam int Y_INIT_D = 240;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_X = 2'd1,
    WR_Y = 2'd2,
    WR_B = 2'd3
  } state_t;

  // Saturate a signed (POS_W+2)-bit sum into [0, max].
  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [POS_W+1:0] sum,
                                                 input logic [POS_W-1:0]        max);
    logic signed [POS_W+1:0] max_s;
    max_s = $signed({2'b00, max});
    if (sum[POS_W+1])
      clamp_pos = '0;
    else if (sum > max_s)
      clamp_pos = max;
    else
      clamp_pos = sum[POS_W-1:0];
  endfunction

endpackage

// File: rtl/cursor_axis_acc.sv
// One cursor axis: position register, signed delta add, clamp to [0, MAX]
// and load of the INIT position. pos_nxt exposes the value the register
// takes on the coming edge so the write sequencer can launch it directly.
module cursor_axis_acc
  import cursor_pkg::*;
#(
  parameter int XW   = POS_W,
  parameter int DW   = 9,
  parameter int MAX  = X_MAX_D,
  parameter int INIT = X_INIT_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_init,
  input  logic                 add_en,
  input  logic signed [DW-1:0] delta,
  output logic        [XW-1:0] pos,
  output logic        [XW-1:0] pos_nxt
);

  localparam logic [XW-1:0] MAX_V  = XW'(MAX);
  localparam logic [XW-1:0] INIT_V = XW'(INIT);

  logic signed [XW+1:0] delta_ext;
  logic signed [XW+1:0] sum;

  // Next position: recenter beats an add; otherwise hold.
  always_comb begin
    delta_ext = {{(XW+2-DW){delta[DW-1]}}, delta};
    sum       = $signed({2'b00, pos}) + delta_ext;
    if (load_init)
      pos_nxt = INIT_V;
    else if (add_en)
      pos_nxt = clamp_pos(sum, MAX_V);
    else
      pos_nxt = pos;
  end

  // Position register, starts centred.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pos <= INIT_V;
    else
      pos <= pos_nxt;
  end

endmodule

// File: rtl/cursor_pos_ctrl.sv
// Cursor position controller: accumulates signed mouse deltas into a clamped
// absolute position and writes X then Y into the cursor PIO registers over an
// Avalon-MM master port. A recenter request returns the cursor to its initial
// position and rewrites the PIOs; one arriving mid-sequence is held pending
// and replayed as soon as the current sequence completes.
// Optional: define CURSOR_BTN_EN to register delta_btn on accept and append a
// third write of the button bits to ADDR_B.
module cursor_pos_ctrl
  import cursor_pkg::*;
#(
  parameter int XW     = POS_W,
  parameter int DW     = 9,
  parameter int X_MAX  = X_MAX_D,
  parameter int Y_MAX  = Y_MAX_D,
  parameter int X_INIT = X_INIT_D,
  parameter int Y_INIT = Y_INIT_D,
  parameter int AW     = 4,
  parameter int ADDR_X = 0,
  parameter int ADDR_Y = 1,
  parameter int ADDR_B = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 delta_valid,
  output logic                 delta_ready,
  input  logic signed [DW-1:0] delta_dx,
  input  logic signed [DW-1:0] delta_dy,
  input  logic        [2:0]    delta_btn,
  input  logic                 recenter,
  output logic        [AW-1:0] avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic        [31:0]   avm_writedata,
  input  logic                 avm_waitrequest,
  output logic                 busy,
  output logic        [XW-1:0] cur_x,
  output logic        [XW-1:0] cur_y
);

  state_t         state;
  logic           rc_pend;
  logic           accept;
  logic           add_en;
  logic           last_wr;
  logic           restart;
  logic           load_init;
  logic [XW-1:0]  x_nxt;
  logic [XW-1:0]  y_nxt_unused;

  // delta_ready is only ever high in IDLE, so accept implies IDLE.
  assign accept    = delta_valid & delta_ready;
  assign add_en    = accept & ~recenter;
`ifdef CURSOR_BTN_EN
  assign last_wr   = (state == WR_B) & ~avm_waitrequest;
`else
  assign last_wr   = (state == WR_Y) & ~avm_waitrequest;
`endif
  assign restart   = last_wr & (rc_pend | recenter);
  assign load_init = ((state == IDLE) & recenter) | restart;

  cursor_axis_acc #(.XW(XW), .DW(DW), .MAX(X_MAX), .INIT(X_INIT)) u_acc_x (
    .clk       (clk),
    .reset     (reset),
    .load_init (load_init),
    .add_en    (add_en),
    .delta     (delta_dx),
    .pos       (cur_x),
    .pos_nxt   (x_nxt)
  );

  cursor_axis_acc #(.XW(XW), .DW(DW), .MAX(Y_MAX), .INIT(Y_INIT)) u_acc_y (
    .clk       (clk),
    .reset     (reset),
    .load_init (load_init),
    .add_en    (add_en),
    .delta     (delta_dy),
    .pos       (cur_y),
    .pos_nxt   (y_nxt_unused)
  );

`ifdef CURSOR_BTN_EN
  logic [2:0] btn_q;

  // Capture the buttons with the delta they arrived with.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      btn_q <= '0;
    else if (accept)
      btn_q <= delta_btn;
  end
`else
  logic unused_btn;
  assign unused_btn = ^{delta_btn, ADDR_B};
`endif

  // Write sequencer: launches X from the value being loaded this edge, then Y
  // (and buttons), holding every avm_* output while the slave stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      delta_ready    <= 1'b0;
      busy           <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      rc_pend        <= 1'b0;
    end else begin
      if ((state != IDLE) && recenter)
        rc_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (accept || recenter) begin
            state          <= WR_X;
            delta_ready    <= 1'b0;
            busy           <= 1'b1;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= AW'(ADDR_X);
            avm_writedata  <= {{(32-XW){1'b0}}, x_nxt};
          end else begin
            delta_ready    <= 1'b1;
          end
        end
        WR_X: begin
          if (!avm_waitrequest) begin
            state         <= WR_Y;
            avm_address   <= AW'(ADDR_Y);
            avm_writedata <= {{(32-XW){1'b0}}, cur_y};
          end
        end
`ifdef CURSOR_BTN_EN
        WR_Y: begin
          if (!avm_waitrequest) begin
            state         <= WR_B;
            avm_address   <= AW'(ADDR_B);
            avm_writedata <= {29'b0, btn_q};
          end
        end
`endif
        default: ;
      endcase
      // Final write done: replay a pending recenter straight away or go idle.
      if (last_wr) begin
        if (restart) begin
          state         <= WR_X;
          rc_pend       <= 1'b0;
          avm_address   <= AW'(ADDR_X);
          avm_writedata <= {{(32-XW){1'b0}}, x_nxt};
        end else begin
          state          <= IDLE;
          busy           <= 1'b0;
          delta_ready    <= 1'b1;
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cursor_pos_ctrl.sv
// Self-checking bench for cursor_pos_ctrl. A transaction-level model tracks
// the expected clamped position and the list of PIO writes it implies; a bus
// monitor records every completed Avalon write for comparison.
module tb_cursor_pos_ctrl;

  localparam int XW = 12;
  localparam int DW = 9;
  localparam int AW = 4;
`ifdef CURSOR_BTN_EN
  localparam int NW = 3;
`else
  localparam int NW = 2;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 delta_valid = 1'b0;
  logic                 delta_ready;
  logic signed [DW-1:0] delta_dx = '0;
  logic signed [DW-1:0] delta_dy = '0;
  logic        [2:0]    delta_btn = 3'b101;
  logic                 recenter = 1'b0;
  logic        [AW-1:0] avm_address;
  logic                 avm_chipselect;
  logic                 avm_write_n;
  logic        [31:0]   avm_writedata;
  logic                 avm_waitrequest = 1'b0;
  logic                 busy;
  logic        [XW-1:0] cur_x;
  logic        [XW-1:0] cur_y;

  int errors = 0;
  int checks = 0;

  typedef struct {int addr; int data; int cyc;} wr_t;
  wr_t log_q[$];
  wr_t exp_q[$];
  int  cyc = 0;
  int  btn_writes = 0;
  int  mx = 320, my = 240, mbtn = 0;

  cursor_pos_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .delta_valid     (delta_valid),
    .delta_ready     (delta_ready),
    .delta_dx        (delta_dx),
    .delta_dy        (delta_dy),
    .delta_btn       (delta_btn),
    .recenter        (recenter),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .cur_x           (cur_x),
    .cur_y           (cur_y)
  );

  always #5 clk = ~clk;

  // Bus monitor: log each write that completes on this edge.
  always @(posedge clk) begin
    cyc++;
    if (avm_chipselect === 1'b1 && avm_write_n === 1'b0 && avm_waitrequest === 1'b0) begin
      log_q.push_back('{int'(avm_address), int'(avm_writedata), cyc});
      if (avm_address == 4'd2) btn_writes++;
    end
  end

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic void push_seq();
    exp_q.push_back('{0, mx, 0});
    exp_q.push_back('{1, my, 0});
`ifdef CURSOR_BTN_EN
    exp_q.push_back('{2, mbtn, 0});
`endif
  endfunction

  function automatic void model_accept(input int dx, input int dy, input int btn, input bit rc);
    mbtn = btn;
    if (rc) begin
      mx = 320;
      my = 240;
    end else begin
      mx = clampi(mx + dx, 639);
      my = clampi(my + dy, 479);
    end
    push_seq();
  endfunction

  // Offer one delta once the DUT is ready. wmode: 0 no stall, 1 random stalls, 2 stall held.
  task automatic do_delta(input int dx, input int dy, input int btn, input bit rc,
                          input int wmode, input bit keep_valid);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      avm_waitrequest = (wmode == 2) ? 1'b1 :
                        ((wmode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0);
      if (delta_ready === 1'b1 || n > 200) break;
      n++;
    end
    if (n > 200) begin
      checks++; errors++;
      $display("FAIL ready_timeout delta_ready stuck at %b after %0d cycles, want 1", delta_ready, n);
      return;
    end
    delta_valid = 1'b1;
    delta_dx    = DW'(dx);
    delta_dy    = DW'(dy);
    delta_btn   = 3'(btn);
    recenter    = rc;
    @(posedge clk); #1;
    if (!keep_valid) delta_valid = 1'b0;
    recenter = 1'b0;
    model_accept(dx, dy, btn, rc);
  endtask

  // Release stalls and wait for the sequencer to go idle.
  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    avm_waitrequest = 1'b0;
    while (!(busy === 1'b0 && delta_ready === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout busy=%b ready=%b, want busy=0 ready=1", busy, delta_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cur_x !== 12'd320) begin errors++; $display("FAIL rst_cur_x got %0d want 320", cur_x); end
    checks++; if (cur_y !== 12'd240) begin errors++; $display("FAIL rst_cur_y got %0d want 240", cur_y); end
    checks++; if (delta_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", delta_ready); end
    checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1) begin errors++;
      $display("FAIL rst_bus cs=%b wn=%b want cs=0 wn=1", avm_chipselect, avm_write_n); end
    checks++; if (avm_address !== 4'd0 || avm_writedata !== 32'd0) begin errors++;
      $display("FAIL rst_addr_data got %0d/%0d want 0/0", avm_address, avm_writedata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (delta_ready !== 1'b0) begin errors++; $display("FAIL ready_early got %b want 0", delta_ready); end
    @(posedge clk); #1;
    checks++; if (delta_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst got %b want 1", delta_ready); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL idle_writes got %0d want 0", log_q.size()); end
  endtask

  task automatic test_basic();
    int c0;
    log_q.delete(); exp_q.delete();
    @(negedge clk);
    avm_waitrequest = 1'b0;
    delta_valid = 1'b1; delta_dx = 9'sd5; delta_dy = -9'sd3; delta_btn = 3'b101;
    @(posedge clk); #1;
    c0 = cyc;
    delta_valid = 1'b0;
    mx = 325; my = 237; mbtn = 5;
    checks++; if (cur_x !== 12'd325 || cur_y !== 12'd237) begin errors++;
      $display("FAIL basic_cur got (%0d,%0d) want (325,237)", cur_x, cur_y); end
    checks++; if (delta_ready !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL basic_busy ready=%b busy=%b want 0/1", delta_ready, busy); end
    checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 4'd0 || avm_writedata !== 32'd325) begin
      errors++; $display("FAIL basic_wr_x cs=%b wn=%b addr=%0d data=%0d want 1/0/0/325",
                         avm_chipselect, avm_write_n, avm_address, avm_writedata); end
    @(posedge clk); #1;
    checks++; if (avm_chipselect !== 1'b1 || avm_address !== 4'd1 || avm_writedata !== 32'd237) begin
      errors++; $display("FAIL basic_wr_y cs=%b addr=%0d data=%0d want 1/1/237",
                         avm_chipselect, avm_address, avm_writedata); end
`ifdef CURSOR_BTN_EN
    @(posedge clk); #1;
    checks++; if (avm_chipselect !== 1'b1 || avm_address !== 4'd2 || avm_writedata !== 32'd5) begin
      errors++; $display("FAIL basic_wr_b cs=%b addr=%0d data=%0d want 1/2/5",
                         avm_chipselect, avm_address, avm_writedata); end
`endif
    @(posedge clk); #1;
    checks++; if (delta_ready !== 1'b1 || busy !== 1'b0 || avm_chipselect !== 1'b0 || avm_write_n !== 1'b1) begin
      errors++; $display("FAIL basic_done ready=%b busy=%b cs=%b wn=%b want 1/0/0/1",
                         delta_ready, busy, avm_chipselect, avm_write_n); end
    checks++; if (log_q.size() != NW) begin errors++; $display("FAIL basic_nwr got %0d want %0d", log_q.size(), NW); end
    if (log_q.size() >= 2) begin
      checks++; if (log_q[0].addr != 0 || log_q[0].data != 325 || log_q[0].cyc != c0 + 1) begin errors++;
        $display("FAIL basic_log_x got %0d/%0d@%0d want 0/325@%0d", log_q[0].addr, log_q[0].data, log_q[0].cyc, c0 + 1); end
      checks++; if (log_q[1].addr != 1 || log_q[1].data != 237 || log_q[1].cyc != c0 + 2) begin errors++;
        $display("FAIL basic_log_y got %0d/%0d@%0d want 1/237@%0d", log_q[1].addr, log_q[1].data, log_q[1].cyc, c0 + 2); end
    end
  endtask

  task automatic test_clamp();
    int dxs[7] = '{255,   50,  100, -256, -256, -256, 255};
    int dys[7] = '{-256,   2, -256,  255,  255,    1,  -1};
    int ex[7]  = '{580,  630,  639,  383,  127,    0, 255};
    int ey[7]  = '{0,      2,    0,  255,  479,  479, 478};
    log_q.delete(); exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      do_delta(dxs[i], dys[i], 5, 1'b0, 0, 1'b0);
      checks++; if (cur_x !== XW'(ex[i]) || cur_y !== XW'(ey[i])) begin errors++;
        $display("FAIL clamp_step%0d got (%0d,%0d) want (%0d,%0d)", i, cur_x, cur_y, ex[i], ey[i]); end
    end
    drain();
    checks++; if (log_q.size() != exp_q.size()) begin errors++;
      $display("FAIL clamp_nwr got %0d want %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i].addr != exp_q[i].addr || log_q[i].data != exp_q[i].data) begin errors++;
        $display("FAIL clamp_wr%0d got %0d/%0d want %0d/%0d", i, log_q[i].addr, log_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
  endtask

  task automatic test_waitrequest();
    log_q.delete(); exp_q.delete();
    do_delta(1, 0, 5, 1'b0, 2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 4'd0 ||
                    avm_writedata !== 32'(mx) || busy !== 1'b1 || delta_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d cs=%b wn=%b addr=%0d data=%0d busy=%b ready=%b want 1/0/0/%0d/1/0",
                           i, avm_chipselect, avm_write_n, avm_address, avm_writedata, busy, delta_ready, mx); end
      if (i != 3) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    avm_waitrequest = 1'b0;
    delta_valid = 1'b0;
    drain();
    checks++; if (cur_x !== XW'(mx)) begin errors++; $display("FAIL stall_no_accept cur_x got %0d want %0d", cur_x, mx); end
    checks++; if (log_q.size() != exp_q.size()) begin errors++;
      $display("FAIL stall_nwr got %0d want %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i].addr != exp_q[i].addr || log_q[i].data != exp_q[i].data) begin errors++;
        $display("FAIL stall_wr%0d got %0d/%0d want %0d/%0d", i, log_q[i].addr, log_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
  endtask

  task automatic test_recenter();
    log_q.delete(); exp_q.delete();
    // Same cycle as a delta: delta is discarded.
    do_delta(50, 0, 5, 1'b1, 0, 1'b0);
    checks++; if (cur_x !== 12'd320 || cur_y !== 12'd240) begin errors++;
      $display("FAIL rc_same_cycle got (%0d,%0d) want (320,240)", cur_x, cur_y); end
    drain();
    // During WR_Y: a second sequence follows with no gap.
    do_delta(10, 10, 5, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    recenter = 1'b1;
    @(posedge clk); #1;
    recenter = 1'b0;
    checks++; if (delta_ready !== 1'b0) begin errors++; $display("FAIL rc_wry_ready got %b want 0", delta_ready); end
    mx = 320; my = 240; push_seq();
    // While stalled in WR_X: held pending until the sequence ends.
    do_delta(-20, -20, 5, 1'b0, 0, 1'b0);
    avm_waitrequest = 1'b1;
    recenter = 1'b1;
    @(posedge clk); #1;
    recenter = 1'b0;
    repeat (2) @(posedge clk);
    mx = 320; my = 240; push_seq();
    drain();
    checks++; if (cur_x !== 12'd320 || cur_y !== 12'd240) begin errors++;
      $display("FAIL rc_final got (%0d,%0d) want (320,240)", cur_x, cur_y); end
    checks++; if (log_q.size() != exp_q.size()) begin errors++;
      $display("FAIL rc_nwr got %0d want %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i].addr != exp_q[i].addr || log_q[i].data != exp_q[i].data) begin errors++;
        $display("FAIL rc_wr%0d got %0d/%0d want %0d/%0d", i, log_q[i].addr, log_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
    if (log_q.size() > 2 * NW) begin
      checks++; if (log_q[2 * NW].cyc != log_q[2 * NW - 1].cyc + 1) begin errors++;
        $display("FAIL rc_back_to_back gap cycles got %0d want 1", log_q[2 * NW].cyc - log_q[2 * NW - 1].cyc); end
    end
  endtask

  task automatic test_random();
    int dx, dy, btn;
    bit rc;
    log_q.delete(); exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      dx  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? -256 : 255)
                                        : (int'($urandom_range(0, 511)) - 256);
      dy  = int'($urandom_range(0, 511)) - 256;
      btn = int'($urandom_range(0, 7));
      rc  = ($urandom_range(0, 7) == 0);
      do_delta(dx, dy, btn, rc, 1, 1'b0);
      checks++; if (cur_x !== XW'(mx) || cur_y !== XW'(my)) begin errors++;
        $display("FAIL rand_cur%0d got (%0d,%0d) want (%0d,%0d)", i, cur_x, cur_y, mx, my); end
    end
    drain();
    checks++; if (log_q.size() != exp_q.size()) begin errors++;
      $display("FAIL rand_nwr got %0d want %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i].addr != exp_q[i].addr || log_q[i].data != exp_q[i].data) begin errors++;
        $display("FAIL rand_wr%0d got %0d/%0d want %0d/%0d", i, log_q[i].addr, log_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
  endtask

  task automatic test_btn_writes();
`ifdef CURSOR_BTN_EN
    checks++; if (btn_writes == 0) begin errors++; $display("FAIL btn_writes got 0 want >0"); end
`else
    checks++; if (btn_writes != 0) begin errors++; $display("FAIL btn_writes got %0d want 0", btn_writes); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_waitrequest();
    test_recenter();
    test_random();
    test_btn_writes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
